// File: rtl/im_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : im_loader_if
// Description : Host-stream and instruction-memory bundle for im_loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface im_loader_if;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        memWrite;
    logic [31:0] pc;
    logic [31:0] dataIn;
    logic        busy;
    logic        done;
    logic [4:0]  count;

    // Host side: issues commands and streams halfwords.
    modport master (
        output start, abort, in_valid, in_data,
        input  in_ready, memWrite, pc, dataIn, busy, done, count
    );

    // Loader side.
    modport slave (
        input  start, abort, in_valid, in_data,
        output in_ready, memWrite, pc, dataIn, busy, done, count
    );
endinterface
`default_nettype wire

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module      : im_loader
// Description : Packs a 16-bit halfword stream into 32-bit words and writes
//               NUM_WORDS of them into an instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module im_loader #(
    parameter int NUM_WORDS = 16,
    parameter bit HI_FIRST  = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    im_loader_if.slave   bus
);

    localparam logic [3:0] C_LAST_IDX = 4'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACC_A = 3'd1,
        S_ACC_B = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    logic [3:0]  r_index;
    logic [4:0]  r_count;
    logic [15:0] r_first;
    logic        r_mem_write;
    logic [31:0] r_pc;
    logic [31:0] r_data_in;

    logic        w_in_ready;
    logic        w_xfer;
    logic [31:0] w_word;

    assign w_in_ready = (r_state == S_ACC_A) || (r_state == S_ACC_B);
    assign w_xfer     = bus.in_valid && w_in_ready;

    // Word assembly: the held halfword plus the one arriving now.
    if (HI_FIRST) begin : g_hi_first
        assign w_word = {r_first, bus.in_data};
    end else begin : g_lo_first
        assign w_word = {bus.in_data, r_first};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_index     <= 4'd0;
            r_count     <= 5'd0;
            r_first     <= 16'd0;
            r_mem_write <= 1'b0;
            r_pc        <= 32'd0;
            r_data_in   <= 32'd0;
        end else begin
            r_mem_write <= 1'b0;
            // Abort drops any partial word; a pulse already on the bus this
            // cycle still completes, but that word is not counted.
            if (bus.abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (bus.start) begin
                            r_state <= S_ACC_A;
                            r_index <= 4'd0;
                            r_count <= 5'd0;
                        end
                    end
                    S_ACC_A: begin
                        if (w_xfer) begin
                            r_first <= bus.in_data;
                            r_state <= S_ACC_B;
                        end
                    end
                    S_ACC_B: begin
                        if (w_xfer) begin
                            r_mem_write <= 1'b1;
                            r_pc        <= {27'd0, r_index, 1'b0};
                            r_data_in   <= w_word;
                            r_state     <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        r_count <= r_count + 5'd1;
                        if (r_index == C_LAST_IDX) begin
                            r_state <= S_DONE;
                        end else begin
                            r_index <= r_index + 4'd1;
                            r_state <= S_ACC_A;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.memWrite = r_mem_write;
    assign bus.pc       = r_pc;
    assign bus.dataIn   = r_data_in;
    assign bus.busy     = (r_state == S_ACC_A) || (r_state == S_ACC_B) ||
                          (r_state == S_WRITE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_im_loader
// Description : Directed bench for im_loader with a halfword-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_im_loader;

    localparam int MW = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic [15:0] in_data;

    always #5 clk = ~clk;

    im_loader_if if_m ();
    im_loader_if if_1 ();
    im_loader_if if_lo ();

    assign if_m.start     = start;
    assign if_m.abort     = abort;
    assign if_m.in_valid  = in_valid;
    assign if_m.in_data   = in_data;
    assign if_1.start     = start;
    assign if_1.abort     = abort;
    assign if_1.in_valid  = in_valid;
    assign if_1.in_data   = in_data;
    assign if_lo.start    = start;
    assign if_lo.abort    = abort;
    assign if_lo.in_valid = in_valid;
    assign if_lo.in_data  = in_data;

    im_loader #(.NUM_WORDS(MW), .HI_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .bus(if_m.slave));
    im_loader #(.NUM_WORDS(1), .HI_FIRST(1'b1)) dut_1 (
        .clk(clk), .reset(reset), .bus(if_1.slave));
    im_loader #(.NUM_WORDS(1), .HI_FIRST(1'b0)) dut_lo (
        .clk(clk), .reset(reset), .bus(if_lo.slave));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model of the 16-word loader in terms of load activity and halfword count.
    bit          m_loading, m_wr, m_done;
    int          m_hw, m_idx, m_cnt;
    logic [15:0] m_first;
    logic [31:0] m_pc, m_data;

    logic [31:0] wr_pc[$];
    logic [31:0] wr_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return m_loading && !m_wr;
    endfunction

    function automatic logic [15:0] hw16(input int k);
        int w;
        w = k / 2;
        if (k % 2 == 0) return 16'hA000 | (16'(w) << 4);
        return 16'h5000 | 16'(w);
    endfunction

    function automatic logic [31:0] word_of(input int w);
        return {16'hA000 | (16'(w) << 4), 16'h5000 | 16'(w)};
    endfunction

    task automatic model_step();
        if (reset) begin
            m_loading = 0; m_wr = 0; m_done = 0; m_hw = 0; m_idx = 0; m_cnt = 0;
            m_first = '0; m_pc = '0; m_data = '0;
        end else if (abort) begin
            m_loading = 0; m_wr = 0; m_hw = 0; m_done = 0;
        end else if (m_wr) begin
            m_wr = 0;
            m_cnt++;
            if (m_idx == MW - 1) begin
                m_loading = 0;
                m_done = 1;
            end else begin
                m_idx++;
            end
        end else if (m_loading) begin
            if (in_valid) begin
                if (m_hw == 0) begin
                    m_first = in_data;
                    m_hw = 1;
                end else begin
                    m_hw = 0;
                    m_wr = 1;
                    m_pc = 32'(m_idx * 2);
                    m_data = {m_first, in_data};
                end
            end
        end else if (start) begin
            m_loading = 1; m_done = 0; m_idx = 0; m_cnt = 0; m_hw = 0;
        end
    endtask

    task automatic compare_all();
        check("in_ready", 32'(if_m.in_ready), 32'(model_ready()));
        check("memWrite", 32'(if_m.memWrite), 32'(m_wr));
        check("pc",       if_m.pc,              m_pc);
        check("dataIn",   if_m.dataIn,          m_data);
        check("busy",     32'(if_m.busy),       32'(m_loading));
        check("done",     32'(if_m.done),       32'(m_done));
        check("count",    32'(if_m.count),      32'(m_cnt));
    endtask

    // One clock: model follows the edge, outputs are compared mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        if (if_m.memWrite) begin
            wr_pc.push_back(if_m.pc);
            wr_data.push_back(if_m.dataIn);
        end
        @(negedge clk);
        if (chk_en) compare_all();
    endtask

    task automatic clear_log();
        wr_pc.delete();
        wr_data.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int k;
        bit xf;

        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 16'h0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_count", 32'(if_m.count), 32'd0);
        check("rst_ready", 32'(if_m.in_ready), 32'd0);
        check("rst_data", if_m.dataIn, 32'd0);
        reset = 1'b0;

        // Single-word load on the NUM_WORDS=1 instances.
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 16'h3CFA; tick();
        in_data = 16'h5888; tick();
        in_valid = 1'b0;
        check("one_mw", 32'(if_1.memWrite), 32'd1);
        check("one_pc", if_1.pc, 32'h0);
        check("one_data", if_1.dataIn, 32'h3CFA5888);
        check("lo_swap_data", if_lo.dataIn, 32'h58883CFA);
        tick();
        check("one_done", 32'(if_1.done), 32'd1);
        check("one_count", 32'(if_1.count), 32'd1);
        check("one_mw_off", 32'(if_1.memWrite), 32'd0);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_busy", 32'(if_m.busy), 32'd0);
        check("abort_count", 32'(if_m.count), 32'd1);

        // Full 16-word load with start held high throughout.
        clear_log();
        start = 1'b1; tick();
        n = 0; k = 0; in_valid = 1'b1;
        while (!if_m.done && n < 200) begin
            in_data = hw16(k);
            xf = model_ready();
            tick();
            n++;
            if (xf) k++;
        end
        start = 1'b0; in_valid = 1'b0;
        check("full_cycles", 32'(n), 32'd48);
        check("full_pulses", 32'(wr_pc.size()), 32'd16);
        check("full_count", 32'(if_m.count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < wr_pc.size()) begin
                check("full_pc", wr_pc[i], 32'(2 * i));
                check("full_data", wr_data[i], word_of(i));
            end
        end
        if (wr_pc.size() == 16) begin
            check("full_last_pc", wr_pc[15], 32'h1E);
            check("full_last_data", wr_data[15], 32'hA0F0500F);
            check("full_first_data", wr_data[0], 32'hA0005000);
        end
        tick();
        check("done_hold", 32'(if_m.done), 32'd1);

        // Stalling stream: in_valid follows 1,0,0,1 repeatedly; restart from DONE.
        clear_log();
        start = 1'b1; tick(); start = 1'b0;
        n = 0; k = 0;
        while (wr_pc.size() < 4 && n < 100) begin
            in_valid = (n % 4 == 0) || (n % 4 == 3);
            in_data = hw16(k);
            xf = in_valid && model_ready();
            tick();
            n++;
            if (xf) k++;
        end
        in_valid = 1'b0;
        check("stall_pulses", 32'(wr_pc.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wr_data.size()) check("stall_data", wr_data[i], word_of(i));
        end
        // Abort during WRITE of the fourth word: pulse completes, not counted.
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_wr_count", 32'(if_m.count), 32'd3);
        check("abort_wr_mw", 32'(if_m.memWrite), 32'd0);

        // Abort in ACC_B of index 3 beats a simultaneous transfer.
        clear_log();
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; k = 0;
        repeat (10) begin
            in_data = hw16(k);
            xf = model_ready();
            tick();
            if (xf) k++;
        end
        check("accb_ready", 32'(if_m.in_ready), 32'd1);
        abort = 1'b1; in_data = hw16(k); tick(); abort = 1'b0; in_valid = 1'b0;
        check("abort_b_busy", 32'(if_m.busy), 32'd0);
        check("abort_b_count", 32'(if_m.count), 32'd3);
        tick(); tick();
        check("no_pc6_write", 32'(wr_pc.size()), 32'd3);
        clear_log();
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; k = 0;
        repeat (3) begin
            in_data = hw16(k);
            xf = model_ready();
            tick();
            if (xf) k++;
        end
        in_valid = 1'b0;
        check("restart_writes", 32'(wr_pc.size()), 32'd1);
        if (wr_pc.size() > 0) check("restart_pc", wr_pc[0], 32'h0);
        abort = 1'b1; tick(); abort = 1'b0;

        // start held, then reset in WRITE of index 4.
        clear_log();
        start = 1'b1; in_valid = 1'b1; k = 0; n = 0;
        tick();
        while (!(if_m.memWrite && if_m.pc == 32'h8) && n < 100) begin
            in_data = hw16(k);
            xf = model_ready();
            tick();
            n++;
            if (xf) k++;
        end
        check("pre_rst_writes", 32'(wr_pc.size()), 32'd5);
        reset = 1'b1; tick();
        start = 1'b0; reset = 1'b0;
        check("post_rst_mw", 32'(if_m.memWrite), 32'd0);
        check("post_rst_pc", if_m.pc, 32'd0);
        check("post_rst_data", if_m.dataIn, 32'd0);
        check("post_rst_busy", 32'(if_m.busy), 32'd0);
        check("post_rst_done", 32'(if_m.done), 32'd0);
        check("post_rst_count", 32'(if_m.count), 32'd0);
        check("post_rst_ready", 32'(if_m.in_ready), 32'd0);
        clear_log();
        repeat (6) tick();
        in_valid = 1'b0;
        check("post_rst_no_write", 32'(wr_pc.size()), 32'd0);

        // Low-half-first packing.
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 16'h1111; tick();
        in_data = 16'h2222; tick();
        in_valid = 1'b0;
        check("lo_mw", 32'(if_lo.memWrite), 32'd1);
        check("lo_pc", if_lo.pc, 32'h0);
        check("lo_data", if_lo.dataIn, 32'h22221111);
        check("hi_data", if_m.dataIn, 32'h11112222);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter NUM_WORDS, default 16, meaning number of 32-bit instruction words written per load (legal range 1..16).
REQ-002 Parameter HI_FIRST, default 1, meaning 1 = first accepted halfword fills bits [31:16], 0 = first fills bits [15:0].
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 start  input  1  begin a load; sampled only in IDLE or DONE.
REQ-006 abort  input  1  cancel the current load; return to IDLE.
REQ-007 in_valid  input  1  in_data holds a valid halfword.
REQ-008 in_data  input  16  instruction halfword from the host stream.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 memWrite  output  1  write strobe to the instruction memory, one cycle per word.
REQ-011 pc  output  32  write address to the instruction memory, {27'b0, index[3:0], 1'b0}.
REQ-012 dataIn  output  32  assembled instruction word to the instruction memory.
REQ-013 busy  output  1  load in progress (ACC_A, ACC_B or WRITE).
REQ-014 done  output  1  load of NUM_WORDS words completed.
REQ-015 count  output  5  number of words written in the current/last load.

Function
REQ-016 The FSM SHALL have states IDLE, ACC_A, ACC_B, WRITE, DONE, all registered.
REQ-017 IDLE: start=1 -> ACC_A, index=0, count=0; otherwise stay.
REQ-018 in_ready SHALL be 1 in ACC_A and ACC_B only, combinationally from state, with no dependency on in_valid.
REQ-019 A halfword SHALL be transferred only on a cycle where in_valid=1 and in_ready=1. in_valid=0 SHALL hold the state indefinitely.
REQ-020 ACC_A on transfer: capture in_data into the first half (per HI_FIRST) -> ACC_B.
REQ-021 ACC_B on transfer: capture in_data into the other half -> WRITE.
REQ-022 In WRITE, memWrite SHALL be 1 for exactly one cycle.
REQ-023 In WRITE, pc={27'b0,index,1'b0} and dataIn is the assembled word.
REQ-024 In WRITE, in_ready SHALL be 0.
REQ-025 On leaving WRITE, count SHALL increment by 1.
REQ-026 On leaving WRITE, if index==NUM_WORDS-1 -> DONE, else index increments by 1 -> ACC_A.
REQ-027 Per-word latency: 2 transfer cycles plus 1 WRITE cycle. Minimum load time SHALL be 3*NUM_WORDS cycles from the first ACC_A cycle to DONE.
REQ-028 The memory samples on negedge. pc, dataIn and memWrite SHALL therefore be registered outputs, stable from posedge to posedge throughout WRITE.
REQ-029 Outside WRITE, memWrite SHALL be 0. pc and dataIn SHALL hold their last values.
REQ-030 DONE: done=1 and busy=0. start=1 -> ACC_A with index=0, count=0, done=0. Otherwise stay.
REQ-031 start SHALL be ignored in ACC_A, ACC_B and WRITE.
REQ-032 abort=1 in any state SHALL force IDLE next cycle with memWrite=0. abort SHALL beat start and beat a simultaneous transfer; a partial word SHALL be discarded and not written. count keeps its value.
REQ-033 An abort during WRITE SHALL still complete that cycle's memWrite pulse, since it is already registered. count SHALL NOT increment for that word.
REQ-034 The index SHALL never exceed NUM_WORDS-1; no wrap-around write to address 0 occurs within one load.

Reset
REQ-035 reset=1 at posedge clk SHALL set state=IDLE, index=0, count=0, memWrite=0, pc=0, dataIn=0, done=0, busy=0, in_ready=0.
REQ-036 reset SHALL take priority over abort, start and transfers, including mid-load; a load interrupted by reset is not resumed.

Verification
REQ-037 reset, start, stream 0x3CFA,0x5888 with in_valid=1 continuously, NUM_WORDS=1 -> WRITE cycle with memWrite=1, pc=0x0, dataIn=0x3CFA5888; next cycle done=1, count=1.
REQ-038 Full load of 16 words (NUM_WORDS=16), in_valid always 1 -> 16 memWrite pulses, pc 0x00,0x02,...,0x1E in order; done after 48 cycles; count=16.
REQ-039 in_valid toggling 1,0,0,1 per halfword -> FSM stalls on in_valid=0 with no extra transfers; dataIn values identical to the back-to-back case.
REQ-040 abort asserted in ACC_B of word 3 -> IDLE next cycle, no write to pc=0x06, count=3; a following start rewrites from pc=0x00.
REQ-041 start held high during the load, then reset asserted in WRITE of word 5 -> start has no effect during the load; after reset all outputs are 0, state is IDLE, and no further memWrite occurs.
REQ-042 HI_FIRST=0, halfwords 0x1111,0x2222 -> dataIn=0x22221111.
